// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;

  localparam int REG_AW  = 5;
  localparam int REG_DW  = 32;
  localparam int REG_NUM = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr and wraps, producing a
// one-hot grant plus its index. Tie ptr to 0 for plain fixed priority.
module rr_arbiter import regfile_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;

  // Two passes: indices at/above ptr first, then the wrapped-around ones below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file write port, with a pending-write
// scoreboard for RAW hazard queries from issue.
// REGFILE_WB_RR_EN: defined -> round-robin priority; undefined -> fixed priority
// (lowest index wins, no pointer register).
module regfile_wb_arbiter import regfile_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_val,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic                  rsv_val,
  input  logic [AW-1:0]         rsv_addr,
  input  logic [AW-1:0]         qaddr0,
  output logic                  qbusy0,
  input  logic [AW-1:0]         qaddr1,
  output logic                  qbusy1,
  output logic                  wen,
  output logic [AW-1:0]         waddr,
  output logic [DW-1:0]         wdata
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int NREG = 1 << AW;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      ptr;
  logic               xfer;
  wb_req_t            win;
  logic [NREG-1:0]    pending;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_val),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // Grant is a pure function of req_val and the pointer, so rdy never loops back.
  assign req_rdy = grant;
  assign xfer    = |(req_val & grant);

  // Select the winner's address/data through the one-hot grant.
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win.addr = req_addr[i*AW +: AW];
        win.data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef REGFILE_WB_RR_EN
  // Priority pointer moves just past the last winner; x0 writes still advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (xfer) ptr <= (int'(gidx) == NUM_REQ-1) ? '0 : gidx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  // Registered write port; writes to x0 are accepted but never assert wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (xfer) begin
      wen   <= (win.addr != REG_ZERO);
      waddr <= win.addr;
      wdata <= win.data;
    end else begin
      wen   <= 1'b0;
    end
  end

  // Pending scoreboard: clear on commit, then set, so a new reservation wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wen)                       pending[waddr]    <= 1'b0;
      if (rsv_val && rsv_addr != '0) pending[rsv_addr] <= 1'b1;
    end
  end

  // The committing write is still invisible to a same-cycle regfile read.
  assign qbusy0 = pending[qaddr0] | (wen && (waddr == qaddr0) && (qaddr0 != '0));
  assign qbusy1 = pending[qaddr1] | (wen && (waddr == qaddr1) && (qaddr1 != '0));

endmodule
